mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one synchronous memory array between two memory-controller requesters.
- Each requester issues a fixed-length burst of reads or writes.
- The arbiter grants the array round-robin, sequences the burst addresses and strobes, and returns read data.
- Sits between the two controller instances and the array's memory-side signals (Addr, DataIn, DataOut, rdEn, wrEn).

Parameters:
- BUSWIDTH, 16, data width; taken from mcDefs.
- ADDRWIDTH, 16, address width; covers the full 64K space.
- BURST_LEN, 4, beats per grant; a power of 2, at least 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- resetN  input  1  asynchronous, active-low reset.
- req  input  2  per-requester burst request; level-sensitive.
- we  input  2  per-requester direction, sampled at grant: 1 = write, 0 = read.
- addr0  input  ADDRWIDTH  requester 0 burst base address, sampled at grant.
- addr1  input  ADDRWIDTH  requester 1 burst base address, sampled at grant.
- wdata0  input  BUSWIDTH  requester 0 write data for the current beat.
- wdata1  input  BUSWIDTH  requester 1 write data for the current beat.
- gnt  output  2  one-hot owner indication, high for the whole burst.
- beat_ack  output  2  owner pulse, one per beat; on writes the requester advances wdata after it.
- rdata  output  BUSWIDTH  registered read data, shared by both requesters.
- rvalid  output  2  one-cycle qualifier for rdata, to the owner only.
- done  output  2  one-cycle end-of-burst pulse to the owner.
- mem_Addr  output  ADDRWIDTH  array address.
- mem_DataIn  output  BUSWIDTH  array write data.
- mem_DataOut  input  BUSWIDTH  array read data; combinational, Z when the location is unwritten.
- mem_rdEn  output  1  array read enable.
- mem_wrEn  output  1  array write enable; the array writes at posedge.

Behaviour:
- Reset (resetN low, asynchronous):
  - State goes to IDLE, owner to 0, last_owner to 1 (so requester 0 wins first), beat to 0.
  - gnt, beat_ack, rvalid, done, mem_rdEn and mem_wrEn all go to 0; rdata, mem_Addr and mem_DataIn go to 0.
- States: IDLE, BURST, DONE.
- IDLE:
  - Memory enables are low.
  - If any req is high at a posedge, move to BURST, choose the owner, latch base = addr_owner and dir = we_owner, and clear beat.
  - Owner selection: the single requester if only one; otherwise !last_owner.
- BURST:
  - gnt[owner] = 1 and beat_ack[owner] = 1 every cycle.
  - mem_Addr = base + beat, computed modulo 2^ADDRWIDTH, so 0xFFFF wraps to 0x0000.
  - Write: mem_wrEn = 1 and mem_DataIn = wdata_owner (combinational pass-through).
  - Read: mem_rdEn = 1; rdata <= mem_DataOut and rvalid[owner] <= 1 at the posedge, so data is visible the cycle after the beat.
  - beat increments each cycle. At beat == BURST_LEN-1, move to DONE and set last_owner = owner.
- DONE:
  - gnt is low and both memory enables are low (turnaround cycle).
  - done[owner] = 1.
  - The final read rvalid appears in this cycle.
  - Always returns to IDLE.
- Latency: req sampled at edge k.
  - gnt and beat 0 occur in cycle k+1; beat j in cycle k+1+j.
  - Read data for beat j is valid in cycle k+2+j.
  - done is in cycle k+1+BURST_LEN.
  - The earliest next grant is cycle k+3+BURST_LEN.
- rdata holds its last value when rvalid is low. Z/X from unwritten locations passes through unchanged; the arbiter does not sanitize it.
- req dropped mid-burst: ignored, the burst completes. req held after done: re-arbitrated in IDLE.
- addr/we changes during BURST: no effect, since both are latched at grant.
- Simultaneous requests: strict alternation while both stay asserted.
- Reset mid-burst: the burst is abandoned immediately. Beats already written remain in the array; no done pulse is issued.
- Every output is low/zero whenever it is not the owner's or not in the stated state.

Decomposition:
- mcDefs additions:
  - arb_state_t enum {IDLE, BURST, DONE}.
  - BURST_LEN constant.
  - ADDRWIDTH constant.
  - requester id type, 1 bit.
- Sub-module rr_pick: 2-way round-robin selector. Inputs req[1:0] and last_owner; outputs owner and any_req; purely combinational. Kept separate so it can be widened later.
- All registers live in mem_arbiter.

Test Plan:
- Write then read back: reset; req[0] write at base 0x0010 with wdata0 = 0xA000..0xA003 per beat_ack, then a read of 0x0010. Required: rdata 0xA000..0xA003, each with rvalid[0], in cycles k+2..k+5; done[0] in cycle k+5.
- Address wrap: requester 1 writes a burst at 0xFFFE. Required: mem_Addr runs 0xFFFE, 0xFFFF, 0x0000, 0x0001; reading back at 0x0000 returns beats 2 and 3.
- Contention: req = 2'b11 held continuously. Required: gnt order 01, 10, 01, 10; every grant lasts exactly BURST_LEN cycles; gnt is low in each DONE cycle.
- Unwritten read: read at 0x8000 after reset. Required: rdata = Z for all 4 rvalid beats; memory enables are never asserted in IDLE/DONE.
- Reset mid-burst: resetN low during beat 2 of a write. Required: all outputs are 0 asynchronously, no done pulse; beats 0–1 are present in the array and beat 2 is not.
- Requester drop: req[0] low after grant. Required: burst still runs 4 beats, then done[0], then IDLE with no regrant.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: data and address
// widths, burst length, FSM state encoding and the requester id type.
package mem_arbiter_pkg;

    localparam int BUSWIDTH  = 16;
    localparam int ADDRWIDTH = 16;
    localparam int BURST_LEN = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    // Identifies one of the two requesters.
    typedef logic req_id_t;

    // One-hot select line for a requester id.
    function automatic logic [1:0] id_onehot(input req_id_t id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin selector. When both requesters ask, the one that did
// not own the array last wins; a lone requester always wins.
module rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_id_t    last_owner_i,
    output req_id_t    owner_o,
    output logic       any_req_o
);

    // Pick the winner from the current request vector and the previous owner.
    always_comb begin
        any_req_o = |req_i;
        case (req_i)
            2'b01:   owner_o = 1'b0;
            2'b10:   owner_o = 1'b1;
            default: owner_o = ~last_owner_i;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory array between two requesters. Each grant is a
// fixed-length burst of reads or writes at consecutive addresses starting at
// the base sampled at grant time; a one-cycle DONE turnaround follows.
//
// Handshake: a requester holds req high (level). At grant the arbiter latches
// that requester's addr and we; gnt stays high for the whole burst and
// beat_ack pulses once per beat. On writes wdata must be valid in a beat's
// cycle and the requester advances it after seeing beat_ack. On reads rdata
// is qualified by rvalid one cycle after the beat. done pulses in the DONE
// cycle. Dropping req mid-burst does not stop the burst.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BUSWIDTH  = mem_arbiter_pkg::BUSWIDTH,
    parameter int ADDRWIDTH = mem_arbiter_pkg::ADDRWIDTH,
    parameter int BURST_LEN = mem_arbiter_pkg::BURST_LEN
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [1:0]           req,
    input  logic [1:0]           we,
    input  logic [ADDRWIDTH-1:0] addr0,
    input  logic [ADDRWIDTH-1:0] addr1,
    input  logic [BUSWIDTH-1:0]  wdata0,
    input  logic [BUSWIDTH-1:0]  wdata1,
    output logic [1:0]           gnt,
    output logic [1:0]           beat_ack,
    output logic [BUSWIDTH-1:0]  rdata,
    output logic [1:0]           rvalid,
    output logic [1:0]           done,
    output logic [ADDRWIDTH-1:0] mem_Addr,
    output logic [BUSWIDTH-1:0]  mem_DataIn,
    input  logic [BUSWIDTH-1:0]  mem_DataOut,
    output logic                 mem_rdEn,
    output logic                 mem_wrEn,
    output arb_state_t           dbg_state_o
);

    // Beat counter width; a single-beat burst still needs one bit.
    localparam int BEATW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEATW-1:0] LAST_BEAT = BEATW'(BURST_LEN - 1);

    arb_state_t            state_q;
    req_id_t               owner_q;
    req_id_t               last_owner_q;
    logic [BEATW-1:0]      beat_q;
    logic [ADDRWIDTH-1:0]  base_q;
    logic                  dir_q;
    logic [BUSWIDTH-1:0]   rdata_q;
    logic [1:0]            rvalid_q;

    req_id_t pick_owner;
    logic    any_req;
    logic    in_burst;

    rr_pick u_rr_pick (
        .req_i        (req),
        .last_owner_i (last_owner_q),
        .owner_o      (pick_owner),
        .any_req_o    (any_req)
    );

    // Arbitration FSM: grant, sequence the burst beats, capture read data.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            beat_q       <= '0;
            base_q       <= '0;
            dir_q        <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    rvalid_q <= 2'b00;
                    if (any_req) begin
                        state_q <= BURST;
                        owner_q <= pick_owner;
                        base_q  <= pick_owner ? addr1 : addr0;
                        dir_q   <= we[pick_owner];
                        beat_q  <= '0;
                    end
                end
                BURST: begin
                    if (!dir_q) begin
                        rdata_q  <= mem_DataOut;
                        rvalid_q <= id_onehot(owner_q);
                    end else begin
                        rvalid_q <= 2'b00;
                    end
                    beat_q <= beat_q + BEATW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_q      <= DONE;
                        last_owner_q <= owner_q;
                    end
                end
                DONE: begin
                    rvalid_q <= 2'b00;
                    state_q  <= IDLE;
                end
                default: begin
                    rvalid_q <= 2'b00;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    // Grant, strobes and array address decoded from the registered state, so
    // an asynchronous reset clears them immediately.
    always_comb begin
        in_burst    = (state_q == BURST);
        gnt         = in_burst ? id_onehot(owner_q) : 2'b00;
        beat_ack    = in_burst ? id_onehot(owner_q) : 2'b00;
        done        = (state_q == DONE) ? id_onehot(owner_q) : 2'b00;
        mem_Addr    = in_burst ? (base_q + ADDRWIDTH'(beat_q)) : '0;
        mem_wrEn    = in_burst & dir_q;
        mem_rdEn    = in_burst & ~dir_q;
        mem_DataIn  = (in_burst && dir_q) ? (owner_q ? wdata1 : wdata0) : '0;
        rdata       = rdata_q;
        rvalid      = rvalid_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural array model: written
// locations return their data, unwritten ones return Z.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        resetN;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic [1:0]  gnt, beat_ack, rvalid, done;
    logic [15:0] rdata, mem_Addr, mem_DataIn, mem_DataOut;
    logic        mem_rdEn, mem_wrEn;
    arb_state_t  dbg_state;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [15:0] z_val;
    logic [15:0] rd_buf [4];
    int          rd_cnt;

    logic [15:0] mem_arr [0:65535];
    bit          written [0:65535];

    mem_arbiter dut (
        .clk         (clk),
        .resetN      (resetN),
        .req         (req),
        .we          (we),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt         (gnt),
        .beat_ack    (beat_ack),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .done        (done),
        .mem_Addr    (mem_Addr),
        .mem_DataIn  (mem_DataIn),
        .mem_DataOut (mem_DataOut),
        .mem_rdEn    (mem_rdEn),
        .mem_wrEn    (mem_wrEn),
        .dbg_state_o (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: write at posedge, combinational read.
    always @(posedge clk) begin
        if (mem_wrEn) begin
            mem_arr[mem_Addr] <= mem_DataIn;
            written[mem_Addr] <= 1'b1;
        end
    end

    always_comb begin
        mem_DataOut = z_val;
        if (written[mem_Addr]) mem_DataOut = mem_arr[mem_Addr];
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_run);
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        resetN = 1'b0;
        req = 2'b00; we = 2'b00;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask

    // Driver: one read burst from requester r; captures rdata on each rvalid[r].
    task automatic rd_burst(input int r, input logic [15:0] base);
        req[r] = 1'b1;
        we[r]  = 1'b0;
        if (r == 0) addr0 = base; else addr1 = base;
        rd_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req[r] = 1'b0;
            if (rvalid[r]) begin
                if (rd_cnt < 4) rd_buf[rd_cnt] = rdata;
                rd_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        req = 2'b11; we = 2'b11;
        addr0 = 16'h1234; addr1 = 16'h5678;
        wdata0 = 16'hFFFF; wdata1 = 16'hFFFF;
        repeat (2) @(negedge clk);
        n_run++;
        if ({gnt, beat_ack, rvalid, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt/ack/rvalid/done=%b want 0", {gnt, beat_ack, rvalid, done});
        end
        n_run++;
        if ({mem_rdEn, mem_wrEn} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_en: rdEn/wrEn=%b want 00", {mem_rdEn, mem_wrEn});
        end
        n_run++;
        if ({mem_Addr, mem_DataIn, rdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h din=%h rdata=%h want 0", mem_Addr, mem_DataIn, rdata);
        end
        n_run++;
        if (dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
    endtask

    task automatic test_write_read();
        logic [15:0] e;
        do_reset();
        req = 2'b01; we = 2'b01; addr0 = 16'h0010; wdata0 = 16'hA000;
        @(negedge clk);
        // Changes after grant must not affect the burst.
        req = 2'b00; we = 2'b00; addr0 = 16'h5555;
        for (int j = 0; j < 4; j++) begin
            wdata0 = 16'hA000 + 16'(j);
            #1;
            n_run++;
            if (gnt !== 2'b01 || beat_ack !== 2'b01) begin
                n_fail++;
                $display("FAIL wr_gnt beat %0d: gnt=%b ack=%b want 01/01", j, gnt, beat_ack);
            end
            n_run++;
            if (mem_wrEn !== 1'b1 || mem_rdEn !== 1'b0) begin
                n_fail++;
                $display("FAIL wr_en beat %0d: wrEn=%b rdEn=%b want 1/0", j, mem_wrEn, mem_rdEn);
            end
            e = 16'h0010 + 16'(j);
            n_run++;
            if (mem_Addr !== e) begin
                n_fail++;
                $display("FAIL wr_addr beat %0d: got %h want %h", j, mem_Addr, e);
            end
            n_run++;
            if (mem_DataIn !== wdata0) begin
                n_fail++;
                $display("FAIL wr_din beat %0d: got %h want %h", j, mem_DataIn, wdata0);
            end
            @(negedge clk);
        end
        n_run++;
        if (gnt !== 2'b00 || done !== 2'b01 || mem_wrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done: gnt=%b done=%b wrEn=%b want 00/01/0", gnt, done, mem_wrEn);
        end
        @(negedge clk);
        n_run++;
        if (done !== 2'b00 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL wr_idle: done=%b state=%0d want 00/IDLE", done, dbg_state);
        end
        // Read back: rvalid in cycles k+2..k+5, done in k+5.
        req = 2'b01; we = 2'b00; addr0 = 16'h0010;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req = 2'b00;
            if (c <= 4) begin
                e = 16'h0010 + 16'(c - 1);
                n_run++;
                if (mem_rdEn !== 1'b1 || mem_Addr !== e) begin
                    n_fail++;
                    $display("FAIL rd_addr cyc %0d: rdEn=%b addr=%h want 1/%h", c, mem_rdEn, mem_Addr, e);
                end
            end
            n_run++;
            if (rvalid !== ((c >= 2 && c <= 5) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL rd_rvalid cyc %0d: got %b", c, rvalid);
            end
            if (c >= 2 && c <= 5) begin
                e = 16'hA000 + 16'(c - 2);
                n_run++;
                if (rdata !== e) begin
                    n_fail++;
                    $display("FAIL rd_data cyc %0d: got %h want %h", c, rdata, e);
                end
            end
            n_run++;
            if (done !== ((c == 5) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL rd_done cyc %0d: got %b", c, done);
            end
        end
        n_run++;
        if (rdata !== 16'hA003) begin
            n_fail++;
            $display("FAIL rd_hold: got %h want a003", rdata);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] e;
        do_reset();
        req = 2'b10; we = 2'b10; addr1 = 16'hFFFE; wdata1 = 16'hB000;
        @(negedge clk);
        req = 2'b00;
        for (int j = 0; j < 4; j++) begin
            wdata1 = 16'hB000 + 16'(j);
            wdata0 = 16'h1234;
            #1;
            e = 16'hFFFE + 16'(j);
            n_run++;
            if (gnt !== 2'b10 || mem_Addr !== e) begin
                n_fail++;
                $display("FAIL wrap_addr beat %0d: gnt=%b addr=%h want 10/%h", j, gnt, mem_Addr, e);
            end
            n_run++;
            if (mem_DataIn !== wdata1) begin
                n_fail++;
                $display("FAIL wrap_din beat %0d: got %h want %h", j, mem_DataIn, wdata1);
            end
            @(negedge clk);
        end
        n_run++;
        if (done !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_done: got %b want 10", done);
        end
        @(negedge clk);
        rd_burst(0, 16'h0000);
        n_run++;
        if (rd_cnt != 4 || rd_buf[0] !== 16'hB002 || rd_buf[1] !== 16'hB003) begin
            n_fail++;
            $display("FAIL wrap_readback: cnt=%0d d0=%h d1=%h want 4/b002/b003", rd_cnt, rd_buf[0], rd_buf[1]);
        end
    endtask

    task automatic test_contention();
        logic [1:0] own, eg, ed;
        do_reset();
        req = 2'b11; we = 2'b00; addr0 = 16'h0010; addr1 = 16'h2000;
        // Period of 6 cycles per grant: 4 beats, DONE, IDLE.
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            own = (((c - 1) / 6) % 2 == 0) ? 2'b01 : 2'b10;
            eg  = (((c - 1) % 6) < 4) ? own : 2'b00;
            ed  = (((c - 1) % 6) == 4) ? own : 2'b00;
            n_run++;
            if (gnt !== eg) begin
                n_fail++;
                $display("FAIL cont_gnt cyc %0d: got %b want %b", c, gnt, eg);
            end
            n_run++;
            if (done !== ed) begin
                n_fail++;
                $display("FAIL cont_done cyc %0d: got %b want %b", c, done, ed);
            end
            if (c == 24) req = 2'b00;
        end
        @(negedge clk);
        n_run++;
        if (gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL cont_release: gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_unwritten();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 16'h8000;
        #1;
        n_run++;
        if (mem_rdEn !== 1'b0 || mem_wrEn !== 1'b0) begin
            n_fail++;
            $display("FAIL unw_idle_en: rdEn=%b wrEn=%b want 0/0", mem_rdEn, mem_wrEn);
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req = 2'b00;
            n_run++;
            if (c <= 4) begin
                if (mem_rdEn !== 1'b1) begin
                    n_fail++;
                    $display("FAIL unw_rden cyc %0d: got %b want 1", c, mem_rdEn);
                end
            end else if (mem_rdEn !== 1'b0 || mem_wrEn !== 1'b0) begin
                n_fail++;
                $display("FAIL unw_en cyc %0d: rdEn=%b wrEn=%b want 0/0", c, mem_rdEn, mem_wrEn);
            end
            if (c >= 2 && c <= 5) begin
                n_run++;
                if (rvalid !== 2'b01 || rdata !== z_val) begin
                    n_fail++;
                    $display("FAIL unw_data cyc %0d: rvalid=%b rdata=%h want 01/z", c, rvalid, rdata);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 2'b01; we = 2'b01; addr0 = 16'h4000; wdata0 = 16'hC000;
        @(negedge clk);
        req = 2'b00; wdata0 = 16'hC000;
        @(negedge clk);
        wdata0 = 16'hC001;
        @(negedge clk);
        wdata0 = 16'hC002;
        #1;
        resetN = 1'b0;
        #1;
        n_run++;
        if ({gnt, beat_ack, rvalid, done, mem_rdEn, mem_wrEn} !== 10'h0) begin
            n_fail++;
            $display("FAIL mid_ctrl: gnt=%b ack=%b rv=%b done=%b rd=%b wr=%b want 0",
                     gnt, beat_ack, rvalid, done, mem_rdEn, mem_wrEn);
        end
        n_run++;
        if ({mem_Addr, mem_DataIn, rdata} !== 48'h0) begin
            n_fail++;
            $display("FAIL mid_data: addr=%h din=%h rdata=%h want 0", mem_Addr, mem_DataIn, rdata);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 2) resetN = 1'b1;
            n_run++;
            if (done !== 2'b00) begin
                n_fail++;
                $display("FAIL mid_nodone cyc %0d: got %b want 00", c, done);
            end
        end
        n_run++;
        if (!written[16'h4000] || mem_arr[16'h4000] !== 16'hC000 ||
            !written[16'h4001] || mem_arr[16'h4001] !== 16'hC001 || written[16'h4002]) begin
            n_fail++;
            $display("FAIL mid_array: w0=%0d d0=%h w1=%0d d1=%h w2=%0d want 1/c000/1/c001/0",
                     written[16'h4000], mem_arr[16'h4000], written[16'h4001], mem_arr[16'h4001],
                     written[16'h4002]);
        end
        rd_burst(0, 16'h4000);
        n_run++;
        if (rd_cnt != 4 || rd_buf[0] !== 16'hC000 || rd_buf[1] !== 16'hC001 || rd_buf[2] !== z_val) begin
            n_fail++;
            $display("FAIL mid_readback: cnt=%0d d0=%h d1=%h d2=%h want 4/c000/c001/z",
                     rd_cnt, rd_buf[0], rd_buf[1], rd_buf[2]);
        end
    endtask

    task automatic test_drop();
        do_reset();
        req = 2'b01; we = 2'b00; addr0 = 16'h0010;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) req = 2'b00;
            n_run++;
            if (gnt !== ((c <= 4) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL drop_gnt cyc %0d: got %b", c, gnt);
            end
            n_run++;
            if (done !== ((c == 5) ? 2'b01 : 2'b00)) begin
                n_fail++;
                $display("FAIL drop_done cyc %0d: got %b", c, done);
            end
            if (c >= 6) begin
                n_run++;
                if (dbg_state !== IDLE) begin
                    n_fail++;
                    $display("FAIL drop_idle cyc %0d: state=%0d want IDLE", c, dbg_state);
                end
            end
        end
    endtask

    initial begin
        z_val = 16'bz;
        test_reset();
        test_write_read();
        test_wrap();
        test_contention();
        test_unwritten();
        test_reset_mid();
        test_drop();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
